poly_voice_synth: RTL and testbench

Polyphonic square-wave note synthesizer with per-voice attack/release envelope, saturating master volume and a single PWM audio output. It replaces the single-voice piano-note top on the Nexys board audio path, driving AUD_PWM (open-drain at the top level) and AUD_SD. Each key input gates one voice at a fixed semitone of a selectable octave. Active voices are summed, scaled by volume, and pulse-width modulated.

---
 rtl/poly_voice_synth_if.sv | 25 ++
 rtl/poly_voice_synth.sv | 279 +++++++++++++++++++++++++++
 tb/tb_poly_voice_synth.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_voice_synth_if.sv
// poly_voice_synth_if: groups the key/octave/button inputs and the audio/status
// outputs of poly_voice_synth. The bench or board wrapper drives the master side.
interface poly_voice_synth_if #(
  parameter int unsigned NUM_VOICES = 12
);
  logic [NUM_VOICES-1:0] key;
  logic [2:0]            octave;
  logic                  vol_up;
  logic                  vol_dn;
  logic                  audio_en;
  logic [3:0]            volume;
  logic [NUM_VOICES-1:0] voice_active;
  logic                  pwm_out;
  logic                  aud_sd;

  modport master (
    output key, octave, vol_up, vol_dn, audio_en,
    input  volume, voice_active, pwm_out, aud_sd
  );

  modport slave (
    input  key, octave, vol_up, vol_dn, audio_en,
    output volume, voice_active, pwm_out, aud_sd
  );
endinterface

// File: rtl/poly_voice_synth.sv
// poly_voice_synth: polyphonic square-wave synthesizer. Each key gates one voice
// at a fixed semitone of the selected octave; active voices are summed, scaled by
// a saturating master volume and pulse-width modulated onto pwm_out.
// Build option: define POLY_SYNTH_ENVELOPE_EN for attack/release amplitude ramps;
// left undefined the voices run in gate mode (instant full amplitude on/off).
module poly_voice_synth #(
  parameter int unsigned NUM_VOICES      = 12,
  parameter int unsigned FIRST_SEMI      = 0,
  parameter int unsigned ENV_STEP_CYCLES = 100000,
  parameter int unsigned VOL_INIT        = 0
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  poly_voice_synth_if.slave bus
);

  localparam int unsigned MIXW = 4 + $clog2(NUM_VOICES + 1);
  localparam int unsigned MW   = MIXW + 4;

  if (NUM_VOICES < 1 || NUM_VOICES > 12 || ENV_STEP_CYCLES < 1 || VOL_INIT > 15) begin : g_bad_param
    $error("poly_voice_synth: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ATTACK  = 2'd1,
    S_SUSTAIN = 2'd2,
    S_RELEASE = 2'd3
  } env_state_t;

  // Octave-1 full periods in clocks, indexed by semitone (0 = C).
  function automatic logic [21:0] f_period(input int unsigned semi);
    case (semi)
      0:       f_period = 22'd3057805;
      1:       f_period = 22'd2886184;
      2:       f_period = 22'd2724194;
      3:       f_period = 22'd2571298;
      4:       f_period = 22'd2426982;
      5:       f_period = 22'd2290765;
      6:       f_period = 22'd2162195;
      7:       f_period = 22'd2040840;
      8:       f_period = 22'd1926296;
      9:       f_period = 22'd1818182;
      10:      f_period = 22'd1716135;
      default: f_period = 22'd1619816;
    endcase
  endfunction

  // ---------------------------------------------------------------- synchronisers
  logic [NUM_VOICES-1:0] r_key_m, r_key_s;
  logic [2:0]            r_oct_m, r_oct_s;
  logic                  r_up_m, r_up_s, r_dn_m, r_dn_s, r_en_m, r_en_s;

  // Two-flop synchronisers on every asynchronous input.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_key_m <= '0;
      r_key_s <= '0;
      r_oct_m <= '0;
      r_oct_s <= '0;
      r_up_m  <= 1'b0;
      r_up_s  <= 1'b0;
      r_dn_m  <= 1'b0;
      r_dn_s  <= 1'b0;
      r_en_m  <= 1'b0;
      r_en_s  <= 1'b0;
    end else begin
      r_key_m <= bus.key;
      r_key_s <= r_key_m;
      r_oct_m <= bus.octave;
      r_oct_s <= r_oct_m;
      r_up_m  <= bus.vol_up;
      r_up_s  <= r_up_m;
      r_dn_m  <= bus.vol_dn;
      r_dn_s  <= r_dn_m;
      r_en_m  <= bus.audio_en;
      r_en_s  <= r_en_m;
    end
  end

  // ---------------------------------------------------------------- volume
  logic       r_up_d, r_dn_d;
  logic [3:0] r_volume;
  logic       w_up_rise, w_dn_rise;

  assign w_up_rise = r_up_s & ~r_up_d;
  assign w_dn_rise = r_dn_s & ~r_dn_d;

  // Saturating volume on button rising edges; simultaneous edges cancel.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_up_d   <= 1'b0;
      r_dn_d   <= 1'b0;
      r_volume <= 4'(VOL_INIT);
    end else begin
      r_up_d <= r_up_s;
      r_dn_d <= r_dn_s;
      if (w_up_rise && !w_dn_rise && r_volume != 4'hF) begin
        r_volume <= r_volume + 4'd1;
      end else if (w_dn_rise && !w_up_rise && r_volume != 4'h0) begin
        r_volume <= r_volume - 4'd1;
      end
    end
  end

`ifdef POLY_SYNTH_ENVELOPE_EN
  // ---------------------------------------------------------------- envelope prescaler
  localparam int unsigned PW = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;
  logic [PW-1:0] r_presc;
  logic          w_step;

  assign w_step = (r_presc == PW'(ENV_STEP_CYCLES - 1));

  // Shared free-running step prescaler.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_step ? '0 : r_presc + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------- envelope FSMs
  env_state_t r_state    [NUM_VOICES];
  env_state_t w_state_nx [NUM_VOICES];
  logic [3:0] r_amp      [NUM_VOICES];
  logic [3:0] w_amp_nx   [NUM_VOICES];

  // Per-voice envelope state and amplitude registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_state[v] <= S_IDLE;
        r_amp[v]   <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_state[v] <= w_state_nx[v];
        r_amp[v]   <= w_amp_nx[v];
      end
    end
  end

  // Per-voice next state: key changes act at once, amplitude moves on steps.
  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      w_state_nx[v] = r_state[v];
      w_amp_nx[v]   = r_amp[v];
`ifdef POLY_SYNTH_ENVELOPE_EN
      case (r_state[v])
        S_IDLE: begin
          if (r_key_s[v]) w_state_nx[v] = S_ATTACK;
        end
        S_ATTACK: begin
          if (!r_key_s[v])             w_state_nx[v] = S_RELEASE;
          else if (r_amp[v] == 4'hF)   w_state_nx[v] = S_SUSTAIN;
          else if (w_step)             w_amp_nx[v]   = r_amp[v] + 4'd1;
        end
        S_SUSTAIN: begin
          if (!r_key_s[v]) w_state_nx[v] = S_RELEASE;
        end
        S_RELEASE: begin
          if (r_key_s[v])              w_state_nx[v] = S_ATTACK;
          else if (r_amp[v] == 4'h0)   w_state_nx[v] = S_IDLE;
          else if (w_step)             w_amp_nx[v]   = r_amp[v] - 4'd1;
        end
        default: begin
          w_state_nx[v] = S_IDLE;
          w_amp_nx[v]   = '0;
        end
      endcase
`else
      case (r_state[v])
        S_IDLE: begin
          if (r_key_s[v]) begin
            w_state_nx[v] = S_SUSTAIN;
            w_amp_nx[v]   = 4'hF;
          end
        end
        S_SUSTAIN: begin
          if (!r_key_s[v]) begin
            w_state_nx[v] = S_IDLE;
            w_amp_nx[v]   = '0;
          end
        end
        default: begin
          w_state_nx[v] = S_IDLE;
          w_amp_nx[v]   = '0;
        end
      endcase
`endif
    end
  end

  logic [NUM_VOICES-1:0] w_active;

  // A voice is reported active whenever its envelope is not idle.
  always_comb begin
    w_active = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      w_active[v] = (r_state[v] != S_IDLE);
    end
  end

  // ---------------------------------------------------------------- tone generators
  logic [20:0]           r_cnt  [NUM_VOICES];
  logic [20:0]           w_half [NUM_VOICES];
  logic [NUM_VOICES-1:0] r_sq;

  // Half-period per voice from the table and the synchronised octave.
  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      w_half[v] = 21'((f_period((FIRST_SEMI + v) % 12) >> r_oct_s) >> 1);
    end
  end

  // Down-counters; the half-period is sampled only at reload, so an octave
  // change never shortens the half-period in progress.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_sq <= '0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        r_cnt[v] <= '0;
      end
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (r_state[v] == S_IDLE) begin
          r_cnt[v] <= w_half[v] - 21'd1;
          r_sq[v]  <= 1'b0;
        end else if (r_cnt[v] == '0) begin
          r_cnt[v] <= w_half[v] - 21'd1;
          r_sq[v]  <= ~r_sq[v];
        end else begin
          r_cnt[v] <= r_cnt[v] - 21'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- mixer and PWM
  logic [MIXW-1:0] w_mix;
  logic [MW-1:0]   w_prod;
  logic [MW-1:0]   r_pwm_cnt;
  logic [MW-1:0]   r_duty;
  logic            r_pwm;
  logic            r_aud_sd;

  // Sum of amplitudes of voices whose square bit is high.
  always_comb begin
    w_mix = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      if (r_sq[v]) w_mix = w_mix + MIXW'(r_amp[v]);
    end
  end

  assign w_prod = MW'(w_mix) * MW'(r_volume);

  // PWM counter, duty latched at wrap, registered output and amplifier enable.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      r_pwm     <= 1'b0;
      r_aud_sd  <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '1) r_duty <= w_prod;
      r_pwm    <= r_en_s & (r_pwm_cnt < r_duty);
      r_aud_sd <= r_en_s;
    end
  end

  assign bus.volume       = r_volume;
  assign bus.voice_active = w_active;
  assign bus.pwm_out      = r_pwm;
  assign bus.aud_sd       = r_aud_sd;

endmodule

// File: tb/tb_poly_voice_synth.sv
// tb_poly_voice_synth: self-checking bench for poly_voice_synth (reset, volume
// table, key latency, envelope or gate mode, tone periods, mixing and PWM).
module tb_poly_voice_synth;

  localparam int unsigned NV = 12;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poly_voice_synth_if #(.NUM_VOICES(NV)) bus ();

  poly_voice_synth #(
    .NUM_VOICES      (NV),
    .FIRST_SEMI      (0),
    .ENV_STEP_CYCLES (4),
    .VOL_INIT        (5)
  ) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rstn),
    .bus        (bus)
  );

  typedef struct {
    logic up;
    logic dn;
    int   exp_vol;
  } vol_vec_t;

  vol_vec_t vtab [53];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_toggle(input int v, input int bound, output int t, output bit ok);
    logic prev;
    prev = dut.r_sq[v];
    ok   = 1'b0;
    t    = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (dut.r_sq[v] != prev) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int v, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (!bus.voice_active[v]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int  m;
    int  k;
    int  t0;
    int  t1;
    int  cnt;
    bit  ok;

    // Volume stimulus table with a saturating reference model.
    m = 5;
    k = 0;
    for (int i = 0; i < 53; i++) begin
      if (i < 20)       begin vtab[i].up = 1'b1; vtab[i].dn = 1'b0; end
      else if (i == 20) begin vtab[i].up = 1'b1; vtab[i].dn = 1'b1; end
      else if (i < 37)  begin vtab[i].up = 1'b0; vtab[i].dn = 1'b1; end
      else if (i == 37) begin vtab[i].up = 1'b1; vtab[i].dn = 1'b1; end
      else              begin vtab[i].up = 1'b1; vtab[i].dn = 1'b0; end
      if (vtab[i].up && !vtab[i].dn && m < 15) m = m + 1;
      if (vtab[i].dn && !vtab[i].up && m > 0)  m = m - 1;
      vtab[i].exp_vol = m;
    end

    bus.key      = '0;
    bus.octave   = 3'd0;
    bus.vol_up   = 1'b0;
    bus.vol_dn   = 1'b0;
    bus.audio_en = 1'b1;

    // Reset values
    rstn = 1'b0;
    repeat (4) tick();
    chk("rst_volume", bus.volume, 5);
    chk("rst_pwm", bus.pwm_out, 0);
    chk("rst_aud_sd", bus.aud_sd, 0);
    chk("rst_active", bus.voice_active, 0);
    rstn = 1'b1;
    tick();
    chk("post_rst_volume", bus.volume, 5);
    chk("post_rst_active", bus.voice_active, 0);
    repeat (3) tick();
    chk("aud_sd_on", bus.aud_sd, 1);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.pwm_out) cnt++;
    end
    chk("duty0_pwm_high", cnt, 0);

    // Volume table through the scoreboard
    for (int i = 0; i < 53; i++) begin
      bus.vol_up = vtab[i].up;
      bus.vol_dn = vtab[i].dn;
      exp_q.push_back(vtab[i].exp_vol);
      repeat (4) tick();
      bus.vol_up = 1'b0;
      bus.vol_dn = 1'b0;
      repeat (3) tick();
      chk($sformatf("vol[%0d]", i), bus.volume, exp_q.pop_front());
    end

    // Button edge to volume change latency
    bus.vol_dn = 1'b1;
    tick(); tick();
    chk("vol_lat_pre", bus.volume, 15);
    tick();
    chk("vol_lat", bus.volume, 14);
    bus.vol_dn = 1'b0;
    repeat (3) tick();
    bus.vol_up = 1'b1;
    repeat (4) tick();
    bus.vol_up = 1'b0;
    repeat (3) tick();
    chk("vol_restore", bus.volume, 15);

    // Key edge to voice_active latency
    bus.key[2] = 1'b1;
    tick(); tick();
    chk("key_lat_pre", bus.voice_active[2], 0);
    tick();
    chk("key_lat", bus.voice_active[2], 1);
`ifndef POLY_SYNTH_ENVELOPE_EN
    chk("gate_amp_on", dut.r_amp[2], 15);
`endif
    bus.key[2] = 1'b0;
    tick(); tick();
    chk("key_rel_pre", bus.voice_active[2], 1);
    tick();
`ifndef POLY_SYNTH_ENVELOPE_EN
    chk("gate_rel", bus.voice_active[2], 0);
    chk("gate_amp_off", dut.r_amp[2], 0);
`else
    wait_idle(2, 200, ok);
    chk("env_rel_idle_v2", ok, 1);

    // Attack ramp timing
    bus.key[0] = 1'b1;
    repeat (3) tick();
    chk("env_active", bus.voice_active[0], 1);
    cnt = 0;
    while (dut.r_amp[0] != 4'hF && cnt < 200) begin
      tick();
      cnt++;
    end
    chk_rng("env_attack_cycles", cnt, 56, 64);
    bus.key[0] = 1'b0;
    repeat (3) tick();
    wait_idle(0, 200, ok);
    chk("env_rel_idle_v0", ok, 1);

    // Release from mid-attack at amp 8
    bus.key[0] = 1'b1;
    cnt = 0;
    while (dut.r_amp[0] != 4'd8 && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("env_reach8", dut.r_amp[0], 8);
    bus.key[0] = 1'b0;
    repeat (3) tick();
    chk("env_rel_amp", dut.r_amp[0], 8);
    cnt = 3;
    while (bus.voice_active[0] && cnt < 200) begin
      tick();
      cnt++;
    end
    chk_rng("env_release_cycles", cnt, 29, 37);
`endif

    // Tone period with a mid-period octave change
    bus.octave = 3'd6;
    repeat (3) tick();
    bus.key[9] = 1'b1;
    wait_toggle(9, 20000, t0, ok);
    chk("tone_first_toggle", ok, 1);
    repeat (3000) tick();
    bus.octave = 3'd7;
    exp_q.push_back(14204);
    exp_q.push_back(7102);
    exp_q.push_back(7102);
    for (int i = 0; i < 3; i++) begin
      wait_toggle(9, 20000, t1, ok);
      if (!ok) chk("tone_toggle_timeout", 0, 1);
      chk($sformatf("tone_interval[%0d]", i), t1 - t0, exp_q.pop_front());
      t0 = t1;
    end
    bus.key[9] = 1'b0;
    repeat (3) tick();
    wait_idle(9, 200, ok);
    chk("tone_idle", ok, 1);

    // Two sustained voices, both squares high, volume 15
    bus.key[0] = 1'b1;
    bus.key[1] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      tick();
      if (dut.r_sq[0] && dut.r_sq[1]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mix_both_high", ok, 1);
    tick();
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (dut.r_pwm_cnt == '0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("mix_wrap_seen", ok, 1);
    chk("mix_duty", dut.r_duty, 450);
    cnt = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      if (bus.pwm_out) cnt++;
    end
    chk("mix_pwm_high", cnt, 450);

    // audio_en low forces pwm_out low while the duty window is open
    bus.audio_en = 1'b0;
    repeat (3) tick();
    chk("aen_pwm", bus.pwm_out, 0);
    chk("aen_aud_sd", bus.aud_sd, 0);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.pwm_out) cnt++;
    end
    chk("aen_pwm_high", cnt, 0);
    chk("aen_voices_run", bus.voice_active[1:0], 3);

    // Asynchronous mid-operation reset
    bus.audio_en = 1'b1;
    repeat (10) tick();
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_volume", bus.volume, 5);
    chk("mid_rst_active", bus.voice_active, 0);
    chk("mid_rst_aud_sd", bus.aud_sd, 0);
    chk("mid_rst_pwm", bus.pwm_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
